// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serial word deserializer: FSM states,
// default widths and a saturating increment.
package serdes_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    // Values are zero-extended to 32 bits so one function serves any width up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter
    import serdes_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk_1,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [31:0] MAX_V = (W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= W'(sat_inc(32'(cnt), MAX_V));
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Framed serial-to-word deserializer feeding a word buffer through a one-word
// pending register; flags and counts framing errors and overflow drops.
module serial_word_deserializer
    import serdes_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              ser_valid,
    input  logic              ser_bit,
    input  logic              buffer_full,
    output logic [DATA_W-1:0] data_1,
    output logic              data_1_en,
    output logic              frame_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output state_t            fsm_state
);

    localparam int BW = $clog2(DATA_W + 1);

    state_t            state, state_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic              pending;
    logic              word_done, bad_stop, load, drop;

    // Handshake: a word transfers on every clk_1 edge where data_1_en=1;
    // data_1_en = pending & ~buffer_full, so full stalls in the same cycle and
    // data_1 stays stable until the edge that transfers it.
    assign data_1_en = pending & ~buffer_full;
    assign load      = word_done & (~pending | data_1_en);
    assign drop      = word_done & pending & ~data_1_en;
    assign fsm_state = state;

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        word_done   = 1'b0;
        bad_stop    = 1'b0;
        if (ser_valid) begin
            case (state)
                IDLE: begin
                    if (!ser_bit) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {shift_reg[DATA_W-2:0], ser_bit};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_W - 1)) state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (ser_bit) word_done = 1'b1;
                    else         bad_stop  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A full slot that is also being drained this edge can take the new word.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            data_1    <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (drop) overflow <= 1'b1;
            if (load) begin
                pending <= 1'b1;
                data_1  <= shift_reg;
            end else if (data_1_en) begin
                pending <= 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk_1 (clk_1),
        .rst   (rst),
        .inc   (drop),
        .cnt   (drop_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_1 (clk_1),
        .rst   (rst),
        .inc   (bad_stop),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer: vector table plus hand-written
// backpressure, saturation and asynchronous-reset sequences.
module tb_serial_word_deserializer;
    import serdes_pkg::*;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              clk_1 = 1'b0;
    logic              rst;
    logic              ser_valid;
    logic              ser_bit;
    logic              buffer_full;
    logic [DATA_W-1:0] data_1;
    logic              data_1_en;
    logic              frame_err;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;
    state_t            fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_fe  = 0;
    logic [DATA_W-1:0] exp_q[$];

    serial_word_deserializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .ser_valid   (ser_valid),
        .ser_bit     (ser_bit),
        .buffer_full (buffer_full),
        .data_1      (data_1),
        .data_1_en   (data_1_en),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .err_cnt     (err_cnt),
        .fsm_state   (fsm_state)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: every buffer write must match the next expected word.
    always @(posedge clk_1) begin
        if (frame_err === 1'b1) n_fe++;
        if (data_1_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %h expected no write", data_1);
            end else begin
                check("write_data", 32'(data_1), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // Ends 1 time unit after the edge that samples the stop bit.
    task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop,
                              input logic toggle, input logic release_full);
        logic b;
        for (int i = 0; i < DATA_W + 2; i++) begin
            if (i == 0)               b = 1'b0;
            else if (i == DATA_W + 1) b = stop;
            else                      b = w[DATA_W - i];
            if (toggle) begin
                ser_valid = 1'b0;
                ser_bit   = ~b;
                tick();
            end
            ser_valid = 1'b1;
            ser_bit   = b;
            if (release_full && i == DATA_W + 1) buffer_full = 1'b0;
            tick();
        end
        ser_valid = 1'b0;
        ser_bit   = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_1"},    32'(data_1),    32'h0);
        check({tag, "_data_1_en"}, 32'(data_1_en), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_overflow"},  32'(overflow),  32'h0);
        check({tag, "_drop_cnt"},  32'(drop_cnt),  32'h0);
        check({tag, "_err_cnt"},   32'(err_cnt),   32'h0);
        check({tag, "_state"},     32'(fsm_state), 32'(IDLE));
    endtask

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              stop;
        logic              toggle;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int exp_err;
        int exp_wr;
        int wr_snap;

        vecs[0] = '{word: 16'hA5C3, stop: 1'b1, toggle: 1'b0};
        vecs[1] = '{word: 16'hA5C3, stop: 1'b1, toggle: 1'b1};
        vecs[2] = '{word: 16'h1234, stop: 1'b0, toggle: 1'b0};
        vecs[3] = '{word: 16'h0001, stop: 1'b1, toggle: 1'b0};
        vecs[4] = '{word: 16'hFFFF, stop: 1'b1, toggle: 1'b1};
        vecs[5] = '{word: 16'h0000, stop: 1'b1, toggle: 1'b0};
        vecs[6] = '{word: 16'h8000, stop: 1'b0, toggle: 1'b1};

        rst         = 1'b1;
        ser_valid   = 1'b0;
        ser_bit     = 1'b1;
        buffer_full = 1'b0;
        #1;
        check_all_zero("reset");
        idle(2);
        rst = 1'b0;
        idle(2);

        // Vector table: framing, MSB-first assembly, qualification, latency.
        exp_err = 0;
        exp_wr  = 0;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].stop) begin
                exp_q.push_back(vecs[v].word);
                exp_wr++;
            end else begin
                exp_err++;
            end
            send_frame(vecs[v].word, vecs[v].stop, vecs[v].toggle, 1'b0);
            check($sformatf("v%0d_en_after_stop", v),  32'(data_1_en), 32'(vecs[v].stop));
            check($sformatf("v%0d_frame_err_pulse", v), 32'(frame_err), 32'(!vecs[v].stop));
            check($sformatf("v%0d_err_cnt", v),        32'(err_cnt),   32'(exp_err));
            idle(3);
            check($sformatf("v%0d_writes", v),     32'(n_wr),      32'(exp_wr));
            check($sformatf("v%0d_fe_pulses", v),  32'(n_fe),      32'(exp_err));
            check($sformatf("v%0d_fe_low", v),     32'(frame_err), 32'h0);
            check($sformatf("v%0d_drop_cnt", v),   32'(drop_cnt),  32'h0);
            check($sformatf("v%0d_queue_empty", v), 32'(exp_q.size()), 32'h0);
        end

        // Backpressure: second word dropped, held word survives.
        apply_reset();
        buffer_full = 1'b1;
        send_frame(16'h1111, 1'b1, 1'b0, 1'b0);
        send_frame(16'h2222, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("ovf_en_low",    32'(data_1_en), 32'h0);
        check("ovf_sticky",    32'(overflow),  32'h1);
        check("ovf_drop_cnt",  32'(drop_cnt),  32'h1);
        check("ovf_held_word", 32'(data_1),    32'h1111);
        wr_snap = n_wr;
        exp_q.push_back(16'h1111);
        buffer_full = 1'b0;
        #1;
        check("ovf_en_comb", 32'(data_1_en), 32'h1);
        idle(3);
        check("ovf_one_write", 32'(n_wr - wr_snap), 32'h1);
        check("ovf_queue",     32'(exp_q.size()),   32'h0);
        check("ovf_still_set", 32'(overflow),       32'h1);

        // Slot freed and refilled on the same edge.
        apply_reset();
        buffer_full = 1'b1;
        send_frame(16'h3333, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        send_frame(16'h4444, 1'b1, 1'b0, 1'b1);
        check("same_edge_data", 32'(data_1),    32'h4444);
        check("same_edge_en",   32'(data_1_en), 32'h1);
        idle(3);
        check("same_edge_queue",    32'(exp_q.size()), 32'h0);
        check("same_edge_drop_cnt", 32'(drop_cnt),     32'h0);
        check("same_edge_overflow", 32'(overflow),     32'h0);

        // Drop counter saturation, then asynchronous reset mid-frame.
        apply_reset();
        buffer_full = 1'b1;
        send_frame(16'hBEEF, 1'b0, 1'b0, 1'b0);
        send_frame(16'h5555, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            send_frame(16'(n), 1'b1, 1'b0, 1'b0);
            if (n == 254) check("sat_at_255", 32'(drop_cnt), 32'd255);
        end
        check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat_err_cnt",  32'(err_cnt),  32'd1);
        check("sat_held",     32'(data_1),   32'h5555);
        ser_valid = 1'b1;
        ser_bit   = 1'b0;
        tick();
        ser_bit = 1'b1;
        idle(5);
        check("midframe_state", 32'(fsm_state), 32'(DATA));
        wr_snap     = n_wr;
        ser_valid   = 1'b0;
        buffer_full = 1'b0;
        rst         = 1'b1;
        #1;
        check_all_zero("async_rst");
        idle(2);
        rst = 1'b0;
        idle(3);
        check("rst_no_write", 32'(n_wr - wr_snap), 32'h0);

        exp_q.push_back(16'hC0DE);
        send_frame(16'hC0DE, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("post_rst_queue", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
